// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StMissReq,
    StMissWait,
    StReplay
  } state_e;

  function automatic int unsigned tag_width(input int unsigned addr_width,
                                            input int unsigned line_bits_log2,
                                            input int unsigned index_width);
    return addr_width - index_width - (line_bits_log2 - 3);
  endfunction

  // Number of 32-bit words per line, as a log2.
  function automatic int unsigned woff_width(input int unsigned line_bits_log2);
    return line_bits_log2 - 5;
  endfunction

  function automatic int unsigned idx_width(input int unsigned index_width);
    return index_width;
  endfunction

endpackage

// File: rtl/icache_ctrl_if.sv
// Fetch, refill and invalidate signals between the cache and its neighbours.
interface icache_ctrl_if #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned LINE_BITS_LOG2 = 8
);

  logic                            cpu_req_valid;
  logic                            cpu_req_ready;
  logic [ADDR_WIDTH-1:0]           cpu_req_addr;
  logic                            cpu_resp_valid;
  logic [31:0]                     cpu_resp_data;
  logic                            mem_req_valid;
  logic                            mem_req_ready;
  logic [ADDR_WIDTH-1:0]           mem_req_addr;
  logic                            mem_resp_valid;
  logic [(2**LINE_BITS_LOG2)-1:0]  mem_resp_data;
  logic                            inv_req;
  logic                            inv_ack;

  // Environment side: fetch unit plus memory.
  modport master (
    output cpu_req_valid, cpu_req_addr, mem_req_ready, mem_resp_valid, mem_resp_data, inv_req,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_data, mem_req_valid, mem_req_addr, inv_ack
  );

  // Cache side.
  modport slave (
    input  cpu_req_valid, cpu_req_addr, mem_req_ready, mem_resp_valid, mem_resp_data, inv_req,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_data, mem_req_valid, mem_req_addr, inv_ack
  );

endinterface

// File: rtl/icache_data_ram.sv
// Line data store: whole-line write, single 32-bit synchronous read port.
module icache_data_ram #(
  parameter int unsigned INDEX_WIDTH    = 7,
  parameter int unsigned LINE_BITS_LOG2 = 8
) (
  input  logic                                   clk_i,
  input  logic                                   we_i,
  input  logic [INDEX_WIDTH-1:0]                 widx_i,
  input  logic [(2**LINE_BITS_LOG2)-1:0]         wline_i,
  input  logic                                   re_i,
  input  logic [INDEX_WIDTH+LINE_BITS_LOG2-6:0]  raddr_i,
  output logic [31:0]                            rdata_o
);

  localparam int unsigned WoffW        = LINE_BITS_LOG2 - 5;
  localparam int unsigned WordsPerLine = 2 ** WoffW;
  localparam int unsigned Depth        = 2 ** (INDEX_WIDTH + WoffW);

  logic [31:0] mem_q [Depth];
  logic [31:0] rdata_q;

  // Word w of the line lands at {index, w}, so word 0 is bits [31:0].
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int w = 0; w < WordsPerLine; w++) begin
        mem_q[{widx_i, WoffW'(w)}] <= wline_i[32*w +: 32];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache: tag store, valid flops, data RAM and refill FSM.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned LINE_BITS_LOG2 = 8,
  parameter int unsigned INDEX_WIDTH    = 7
) (
  input logic         clock,
  input logic         reset_n,
  icache_ctrl_if.slave bus
);

  localparam int unsigned TagW  = tag_width(ADDR_WIDTH, LINE_BITS_LOG2, INDEX_WIDTH);
  localparam int unsigned WoffW = woff_width(LINE_BITS_LOG2);
  localparam int unsigned IdxW  = idx_width(INDEX_WIDTH);
  localparam int unsigned OffLo = LINE_BITS_LOG2 - 3;
  localparam int unsigned Lines = 2 ** IdxW;

  state_e            state_q, state_d;
  logic [TagW-1:0]   tag_q, tag_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WoffW-1:0]  woff_q, woff_d;
  logic [Lines-1:0]  valid_q, valid_d;

  logic [TagW-1:0]   req_tag;
  logic [IdxW-1:0]   req_idx;
  logic [WoffW-1:0]  req_woff;

  logic              rd_en;
  logic [IdxW-1:0]   rd_idx;
  logic [WoffW-1:0]  rd_woff;
  logic              wr_en;
  logic              hit;
  logic              accept;
  logic              req_ready;
  logic              resp_valid;
  logic              mreq_valid;
  logic              inv_ack;
  logic [31:0]       ram_rdata;

  logic [TagW-1:0]   tag_mem [Lines];
  logic [TagW-1:0]   tag_rdata_q;

  logic              unused_addr;
  assign unused_addr = ^bus.cpu_req_addr[1:0];

  assign req_woff = bus.cpu_req_addr[WoffW+1:2];
  assign req_idx  = bus.cpu_req_addr[OffLo +: IdxW];
  assign req_tag  = bus.cpu_req_addr[ADDR_WIDTH-1 -: TagW];

  assign hit = valid_q[idx_q] && (tag_rdata_q == tag_q);

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    idx_d      = idx_q;
    woff_d     = woff_q;
    valid_d    = valid_q;
    rd_en      = 1'b0;
    rd_idx     = req_idx;
    rd_woff    = req_woff;
    wr_en      = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mreq_valid = 1'b0;
    inv_ack    = 1'b0;
    accept     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Invalidate wins over a simultaneous fetch.
        if (bus.inv_req) begin
          valid_d = '0;
          inv_ack = 1'b1;
        end else begin
          req_ready = 1'b1;
        end
      end
      StLookup: begin
        if (hit) begin
          resp_valid = 1'b1;
          req_ready  = 1'b1;
          state_d    = StIdle;
        end else begin
          state_d = StMissReq;
        end
      end
      StMissReq: begin
        mreq_valid = 1'b1;
        if (bus.mem_req_ready) begin
          state_d = StMissWait;
        end
      end
      StMissWait: begin
        if (bus.mem_resp_valid) begin
          wr_en          = 1'b1;
          valid_d[idx_q] = 1'b1;
          state_d        = StReplay;
        end
      end
      StReplay: begin
        rd_en   = 1'b1;
        rd_idx  = idx_q;
        rd_woff = woff_q;
        state_d = StLookup;
      end
      default: state_d = StIdle;
    endcase

    accept = req_ready && bus.cpu_req_valid;
    if (accept) begin
      rd_en   = 1'b1;
      tag_d   = req_tag;
      idx_d   = req_idx;
      woff_d  = req_woff;
      state_d = StLookup;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      tag_q   <= '0;
      idx_q   <= '0;
      woff_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      woff_q  <= woff_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_mem[idx_q] <= tag_q;
    end
    if (rd_en) begin
      tag_rdata_q <= tag_mem[rd_idx];
    end
  end

  icache_data_ram #(
    .INDEX_WIDTH    (IdxW),
    .LINE_BITS_LOG2 (LINE_BITS_LOG2)
  ) u_data_ram (
    .clk_i   (clock),
    .we_i    (wr_en),
    .widx_i  (idx_q),
    .wline_i (bus.mem_resp_data),
    .re_i    (rd_en),
    .raddr_i ({rd_idx, rd_woff}),
    .rdata_o (ram_rdata)
  );

  // Data and address outputs read as zero whenever their valid is low.
  assign bus.cpu_req_ready  = req_ready;
  assign bus.cpu_resp_valid = resp_valid;
  assign bus.cpu_resp_data  = resp_valid ? ram_rdata : 32'h0;
  assign bus.mem_req_valid  = mreq_valid;
  assign bus.mem_req_addr   = mreq_valid ? {tag_q, idx_q, {OffLo{1'b0}}} : '0;
  assign bus.inv_ack        = inv_ack;

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed scenarios plus a randomized run
// checked every cycle against a transaction-level cache model.
module tb_icache_ctrl;

  logic clock;
  logic reset_n;

  icache_ctrl_if #(.ADDR_WIDTH(32), .LINE_BITS_LOG2(8)) bus ();

  icache_ctrl #(
    .ADDR_WIDTH     (32),
    .LINE_BITS_LOG2 (8),
    .INDEX_WIDTH    (7)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the cache contents and of where the current access stands.
  localparam int MWaitFetch = 0;
  localparam int MLook      = 1;
  localparam int MLineReq   = 2;
  localparam int MLineWait  = 3;
  localparam int MReplay    = 4;

  bit          m_valid [128];
  logic [31:0] m_tag   [128];
  logic [31:0] m_data  [128][8];
  int          m_mode;
  logic [31:0] m_addr;

  logic        e_ready, e_rv, e_mv, e_ack;
  logic [31:0] e_rd, e_ma;
  logic        s_ready, s_rv, s_mv, s_ack;
  logic [31:0] s_rd, s_ma;

  function automatic int unsigned f_idx(input logic [31:0] a);
    return (a >> 5) % 128;
  endfunction
  function automatic logic [31:0] f_tag(input logic [31:0] a);
    return a >> 12;
  endfunction
  function automatic int unsigned f_word(input logic [31:0] a);
    return (a >> 2) % 8;
  endfunction
  function automatic logic [255:0] pat(input logic [31:0] base);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = base + i;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    m_mode = MWaitFetch;
    m_addr = '0;
  endtask

  task automatic model_step(input bit hit);
    case (m_mode)
      MWaitFetch: begin
        if (bus.inv_req) begin
          foreach (m_valid[i]) m_valid[i] = 1'b0;
        end else if (bus.cpu_req_valid) begin
          m_addr = bus.cpu_req_addr;
          m_mode = MLook;
        end
      end
      MLook: begin
        if (!hit) m_mode = MLineReq;
        else if (bus.cpu_req_valid) m_addr = bus.cpu_req_addr;
        else m_mode = MWaitFetch;
      end
      MLineReq: if (bus.mem_req_ready) m_mode = MLineWait;
      MLineWait: begin
        if (bus.mem_resp_valid) begin
          for (int w = 0; w < 8; w++) m_data[f_idx(m_addr)][w] = bus.mem_resp_data[32*w +: 32];
          m_tag[f_idx(m_addr)]   = f_tag(m_addr);
          m_valid[f_idx(m_addr)] = 1'b1;
          m_mode = MReplay;
        end
      end
      default: m_mode = MLook;
    endcase
  endtask

  // One clock: predict, compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    bit hit;
    if (!reset_n) model_reset();
    hit = (m_mode == MLook) && m_valid[f_idx(m_addr)] &&
          (m_tag[f_idx(m_addr)] == f_tag(m_addr));
    e_ready = ((m_mode == MWaitFetch) && !bus.inv_req) || hit;
    e_rv    = hit;
    e_rd    = hit ? m_data[f_idx(m_addr)][f_word(m_addr)] : 32'h0;
    e_mv    = (m_mode == MLineReq);
    e_ma    = e_mv ? (m_addr & ~32'h1F) : 32'h0;
    e_ack   = (m_mode == MWaitFetch) && bus.inv_req;
    @(negedge clock);
    s_ready = bus.cpu_req_ready;
    s_rv    = bus.cpu_resp_valid;
    s_rd    = bus.cpu_resp_data;
    s_mv    = bus.mem_req_valid;
    s_ma    = bus.mem_req_addr;
    s_ack   = bus.inv_ack;
    check("cpu_req_ready",  s_ready, e_ready);
    check("cpu_resp_valid", s_rv,    e_rv);
    check("cpu_resp_data",  s_rd,    e_rd);
    check("mem_req_valid",  s_mv,    e_mv);
    check("mem_req_addr",   s_ma,    e_ma);
    check("inv_ack",        s_ack,   e_ack);
    @(posedge clock);
    if (reset_n) model_step(hit);
    #1;
  endtask

  task automatic fetch_miss(input logic [31:0] a, input int k, output logic [31:0] d);
    logic [31:0] la;
    la = a & ~32'h1F;
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr  = a;
    tick();
    bus.cpu_req_valid = 1'b0;
    tick();
    check("miss_lookup_no_resp", s_rv, 1'b0);
    for (int i = 0; i < k; i++) begin
      tick();
      check("bp_mem_req_valid", s_mv, 1'b1);
      check("bp_mem_req_addr", s_ma, la);
      check("bp_cpu_req_ready", s_ready, 1'b0);
    end
    bus.mem_req_ready = 1'b1;
    tick();
    check("refill_mem_req_addr", s_ma, la);
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    tick();
    bus.mem_resp_valid = 1'b0;
    tick();
    tick();
    check("replay_resp_valid", s_rv, 1'b1);
    d = s_rd;
  endtask

  initial begin
    logic [31:0] d;
    logic        last_ack;
    logic [255:0] line;

    reset_n            = 1'b0;
    bus.cpu_req_valid  = 1'b0;
    bus.cpu_req_addr   = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    bus.inv_req        = 1'b0;
    model_reset();
    tick();
    check("reset_cpu_req_ready", s_ready, 1'b1);
    check("reset_resp_data", s_rd, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();

    // Cold miss with zero-wait memory: response five cycles after accept.
    bus.mem_resp_data = pat(32'hA000_0000);
    fetch_miss(32'h0000_1004, 0, d);
    check("cold_miss_req_addr", s_ma, 32'h0);
    check("cold_miss_data", d, 32'hA000_0001);

    // Eight back-to-back hits across the refilled line.
    for (int i = 0; i <= 8; i++) begin
      bus.cpu_req_valid = (i < 8);
      bus.cpu_req_addr  = 32'h0000_1000 + 32'(4 * i);
      tick();
      if (i >= 1) begin
        check("b2b_valid", s_rv, 1'b1);
        check("b2b_data", s_rd, 32'hA000_0000 + 32'(i - 1));
        check("b2b_no_mem_req", s_mv, 1'b0);
      end
    end
    bus.cpu_req_valid = 1'b0;
    tick();

    // Conflict miss, then refetch of the evicted line under back-pressure.
    bus.mem_resp_data = pat(32'hB000_0000);
    fetch_miss(32'h0000_2008, 0, d);
    check("conflict_data", d, 32'hB000_0002);
    bus.mem_resp_data = pat(32'hC000_0000);
    fetch_miss(32'h0000_1000, 4, d);
    check("refetch_data", d, 32'hC000_0000);

    // Hit, then invalidate colliding with a fetch in idle.
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr  = 32'h0000_100C;
    tick();
    bus.cpu_req_valid = 1'b0;
    tick();
    check("pre_inv_hit_data", s_rd, 32'hC000_0003);
    bus.inv_req       = 1'b1;
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr  = 32'h0000_1000;
    tick();
    check("inv_ack_pulse", s_ack, 1'b1);
    check("inv_blocks_fetch", s_ready, 1'b0);
    bus.inv_req       = 1'b0;
    bus.cpu_req_valid = 1'b0;
    tick();
    check("inv_ack_single", s_ack, 1'b0);
    bus.mem_resp_data = pat(32'hD000_0000);
    fetch_miss(32'h0000_1000, 0, d);
    check("post_inv_data", d, 32'hD000_0000);

    // Reset while waiting for the line; the late beat must be dropped.
    bus.mem_resp_data = pat(32'hE000_0000);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr  = 32'h0000_5000;
    tick();
    bus.cpu_req_valid = 1'b0;
    tick();
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    check("midreset_ready", s_ready, 1'b1);
    check("midreset_mem_req", s_mv, 1'b0);
    reset_n            = 1'b1;
    bus.mem_resp_valid = 1'b1;
    tick();
    check("late_beat_ignored", s_mv, 1'b0);
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = pat(32'hF000_0000);
    fetch_miss(32'h0000_5004, 0, d);
    check("post_reset_data", d, 32'hF000_0001);

    // Randomized traffic on a few indices and tags to force hits and conflicts.
    last_ack = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      bus.cpu_req_valid  = ($urandom % 3) != 0;
      bus.cpu_req_addr   = ($urandom_range(0, 2) << 12) | ($urandom_range(0, 3) << 5) |
                           ($urandom % 32);
      bus.mem_req_ready  = ($urandom % 2) != 0;
      bus.mem_resp_valid = ($urandom % 3) == 0;
      for (int w = 0; w < 8; w++) line[32*w +: 32] = $urandom;
      bus.mem_resp_data  = line;
      if (bus.inv_req && last_ack) bus.inv_req = 1'b0;
      else if (!bus.inv_req && ($urandom % 40) == 0) bus.inv_req = 1'b1;
      reset_n = ($urandom % 700) != 0;
      if (!reset_n) bus.inv_req = 1'b0;
      tick();
      last_ack = e_ack;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Direct-mapped, parametrised instruction cache for the fetch stage: tag store, valid bits, line data store and a refill state machine behind a single fetch port. It sits between the fetch unit and the memory/bus interface. Hits are served with 1-cycle latency. Misses fetch a whole line in one beat and replay the access. A single-request invalidate (fence.i) clears the whole cache.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- LINE_BITS_LOG2, 8, log2 of line width in bits (256-bit line, 8 words)
- INDEX_WIDTH, 7, log2 of line count (128 lines, 4 KiB)

Ports (the fetch word is always 32 bits):
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- cpu_req_valid  in  1  fetch request
- cpu_req_ready  out  1  request accepted when valid&&ready
- cpu_req_addr  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored
- cpu_resp_valid  out  1  single-cycle pulse, data valid
- cpu_resp_data  out  32  instruction word
- mem_req_valid  out  1  line refill request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_WIDTH  line-aligned address, low LINE_BITS_LOG2-3 bits zero
- mem_resp_valid  in  1  single-cycle pulse, line data valid
- mem_resp_data  in  2**LINE_BITS_LOG2  full line, word 0 in bits [31:0]
- inv_req  in  1  invalidate-all request, held until acknowledged
- inv_ack  out  1  single-cycle pulse, invalidate done

## Operation
- Address split:
  - word offset: addr[LINE_BITS_LOG2-4:2]
  - index: next INDEX_WIDTH bits
  - tag: remaining TAG_WIDTH = ADDR_WIDTH-INDEX_WIDTH-(LINE_BITS_LOG2-3) bits (default 20)
- Storage:
  - tag array and data array are synchronous-read RAMs
  - valid bits are flops, cleared in one cycle
- FSM states:
  - IDLE: cpu_req_ready=1 unless inv_req is high. On accept, read the tag and data arrays at the index, latch the address, go to LOOKUP. If inv_req is high: clear all valid bits, pulse inv_ack, stay in IDLE; inv_req has priority over cpu_req.
  - LOOKUP: hit = valid[idx] && tag match.
    - Hit: cpu_resp_valid=1 with the selected word. cpu_req_ready=1 (back-to-back fetch); a new accept stays in LOOKUP, otherwise go to IDLE.
    - Miss: cpu_req_ready=0, go to MISS_REQ.
  - MISS_REQ: mem_req_valid=1 with the line address, held stable until mem_req_ready, then go to MISS_WAIT.
  - MISS_WAIT: on mem_resp_valid, write the line, tag and valid[idx]=1, go to REPLAY.
  - REPLAY: re-read both arrays at the latched index, go to LOOKUP, which then hits.
- The response has no back-pressure; the fetch stage always accepts cpu_resp_data.
- inv_req is serviced only in IDLE. A request raised in other states waits, and cpu_req_ready stays 0 once the FSM reaches IDLE.
- mem_resp_valid outside MISS_WAIT is ignored.

## Timing
- Reset values: FSM=IDLE, all valid bits 0, cpu_req_ready=1, cpu_resp_valid=0, mem_req_valid=0, mem_req_addr=0, inv_ack=0, cpu_resp_data=0.
- Hit latency: response in the cycle after the accept edge. Sustained throughput is 1 fetch/cycle on consecutive hits.
- Miss latency: accept(0), LOOKUP(1), MISS_REQ from cycle 2 (k≥1 cycles until mem_req_ready), MISS_WAIT (m≥1 cycles), REPLAY, LOOKUP. Response arrives at cycle 2+k+m+1 minimum, i.e. cycle 5 with zero-wait memory.
- Refill write and replay read of the same index never occur in the same cycle.
- Reset asserted mid-refill: immediate return to IDLE, valid cleared; the outstanding memory beat is dropped.

## Structure
- Shared package icache_pkg:
  - state enum (IDLE, LOOKUP, MISS_REQ, MISS_WAIT, REPLAY)
  - localparam functions for TAG_WIDTH, word-offset width and index width
- Sub-module icache_data_ram:
  - wide line write, 32-bit synchronous read port
  - 2**(INDEX_WIDTH+LINE_BITS_LOG2-5) words
  - write expands the line into consecutive words at {index, word}
- Tag array is an inline synchronous RAM in icache_ctrl.

## Test plan
- Cold miss: fetch 0x0000_1004, memory returns a line with word i = 0xA000_0000+i. Expected: mem_req_addr=0x0000_1000, then cpu_resp_data=0xA000_0001 five cycles after accept with zero-wait memory.
- Back-to-back hits: fetch 0x1000..0x101C on consecutive cycles after the refill. Expected: 8 responses on 8 consecutive cycles, data 0xA000_0000..0xA000_0007, no mem_req_valid.
- Conflict miss: fetch 0x0000_2000 (same index, different tag), then 0x1000 again. Expected: two refills; the second returns the refetched data.
- Memory back-pressure: hold mem_req_ready=0 for 4 cycles. Expected: mem_req_valid and mem_req_addr stable throughout, cpu_req_ready=0 throughout.
- Invalidate: after a hit on 0x1000, assert inv_req together with cpu_req_valid in IDLE. Expected: inv_ack pulses, request not accepted that cycle, next fetch of 0x1000 misses.
- Reset during MISS_WAIT, then late mem_resp_valid. Expected: outputs at reset values, response ignored, next fetch misses.
